// File: rtl/dcache_pkg.sv
// Shared constants, line type and byte-merge helper for the dcache main pipe.
// FSM encodings are plain localparams so legacy blocks can reuse them.
package dcache_pkg;

  localparam int TAG_W = 20;
  localparam int IDX_W = 8;
  localparam int WAYS  = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WB   = 3'd1;
  localparam state_t ST_REQ  = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_RESP = 3'd4;

  typedef logic [3:0][31:0] line_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  mask
  );
    logic [31:0] r;
    r = old;
    for (int j = 0; j < 4; j++)
      if (mask[j]) r[j*8 +: 8] = nw[j*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dcache_main_pipe_if.sv
// Request, array-write, memory and response bundle of the dcache main pipe.
// slave = the pipe itself, master = arbiter/array/memory side.
interface dcache_main_pipe_if;
  import dcache_pkg::*;

  logic             in_ready;
  logic             in_valid;
  logic [31:0]      in_addr;
  logic             in_hit;
  logic [WAYS-1:0]  in_chosen_way;
  logic             in_is_dirty_way;
  logic [TAG_W-1:0] in_dirty_tag;
  logic [127:0]     in_data;
  logic             in_is_store;
  logic [31:0]      in_store_data;
  logic [3:0]       in_store_mask;

  logic             arr_wen;
  logic [IDX_W-1:0] arr_idx;
  logic [WAYS-1:0]  arr_way;
  logic [TAG_W-1:0] arr_tag;
  logic [127:0]     arr_data;
  logic             arr_dirty;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_write;
  logic [31:0]      mem_req_addr;
  logic [127:0]     mem_req_data;
  logic             mem_resp_valid;
  logic [127:0]     mem_resp_data;

  logic             resp_valid;
  logic [31:0]      resp_data;

  modport slave (
    output in_ready,
    input  in_valid, in_addr, in_hit, in_chosen_way,
    input  in_is_dirty_way, in_dirty_tag, in_data,
    input  in_is_store, in_store_data, in_store_mask,
    output arr_wen, arr_idx, arr_way, arr_tag,
    output arr_data, arr_dirty,
    output mem_req_valid, mem_req_write,
    output mem_req_addr, mem_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output resp_valid, resp_data
  );

  modport master (
    input  in_ready,
    output in_valid, in_addr, in_hit, in_chosen_way,
    output in_is_dirty_way, in_dirty_tag, in_data,
    output in_is_store, in_store_data, in_store_mask,
    input  arr_wen, arr_idx, arr_way, arr_tag,
    input  arr_data, arr_dirty,
    input  mem_req_valid, mem_req_write,
    input  mem_req_addr, mem_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  resp_valid, resp_data
  );

endinterface

// File: rtl/dcache_store_merge.sv
// Combinational store merge: replaces masked bytes of the selected word.
// Also returns the post-merge selected word for load responses.
module dcache_store_merge
  import dcache_pkg::*;
(
  input  line_t       line,
  input  logic [1:0]  sel,
  input  logic [31:0] data,
  input  logic [3:0]  mask,
  input  logic        en,
  output line_t       merged,
  output logic [31:0] word
);

  always_comb begin
    merged = line;
    if (en)
      merged[sel] = merge_bytes(line[sel], data, mask);
  end

  assign word = merged[sel];

endmodule

// File: rtl/dcache_main_pipe.sv
// Dcache main pipe: hit/store-merge, dirty writeback and refill FSM.
// Optional DCACHE_PERF_CNT_EN adds perf_hit_cnt/perf_miss_cnt outputs.
module dcache_main_pipe
  import dcache_pkg::*;
(
  input  logic clock,
  input  logic reset,
  dcache_main_pipe_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  state_t           state;
  logic [31:2]      addr_q;
  logic             hit_q;
  logic [WAYS-1:0]  way_q;
  logic             dirty_q;
  logic [TAG_W-1:0] dtag_q;
  line_t            line_q;
  line_t            fill_q;
  logic             st_q;
  logic [31:0]      sdata_q;
  logic [3:0]       smask_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      dirty_q <= 1'b0;
      dtag_q  <= '0;
      line_q  <= '0;
      fill_q  <= '0;
      st_q    <= 1'b0;
      sdata_q <= '0;
      smask_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (bus.in_valid) begin
          addr_q  <= bus.in_addr[31:2];
          hit_q   <= bus.in_hit;
          way_q   <= bus.in_chosen_way;
          dirty_q <= bus.in_is_dirty_way;
          dtag_q  <= bus.in_dirty_tag;
          line_q  <= bus.in_data;
          st_q    <= bus.in_is_store;
          sdata_q <= bus.in_store_data;
          smask_q <= bus.in_store_mask;
          if (bus.in_hit)               state <= ST_RESP;
          else if (bus.in_is_dirty_way) state <= ST_WB;
          else                          state <= ST_REQ;
        end
        ST_WB:   if (bus.mem_req_ready) state <= ST_REQ;
        ST_REQ:  if (bus.mem_req_ready) state <= ST_WAIT;
        ST_WAIT: if (bus.mem_resp_valid) begin
          fill_q <= bus.mem_resp_data;
          state  <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic        in_resp;
  logic        in_wb;
  line_t       merged;
  logic [31:0] word;

  assign in_resp = (state == ST_RESP);
  assign in_wb   = (state == ST_WB);

  dcache_store_merge u_merge (
    .line   (hit_q ? line_q : fill_q),
    .sel    (addr_q[3:2]),
    .data   (sdata_q),
    .mask   (smask_q),
    .en     (st_q),
    .merged (merged),
    .word   (word)
  );

  assign bus.in_ready = (state == ST_IDLE);

  assign bus.arr_wen   = in_resp & (st_q | ~hit_q);
  assign bus.arr_idx   = addr_q[11:4];
  assign bus.arr_way   = way_q;
  assign bus.arr_tag   = addr_q[31:12];
  assign bus.arr_data  = merged;
  assign bus.arr_dirty = st_q | (hit_q & dirty_q);

  // Writeback targets the victim's tag; refill targets the request's tag.
  assign bus.mem_req_valid = in_wb | (state == ST_REQ);
  assign bus.mem_req_write = in_wb;
  assign bus.mem_req_addr  = in_wb ? {dtag_q, addr_q[11:4], 4'h0}
                                   : {addr_q[31:12], addr_q[11:4], 4'h0};
  assign bus.mem_req_data  = line_q;

  assign bus.resp_valid = in_resp;
  assign bus.resp_data  = (in_resp & ~st_q) ? word : 32'h0;

`ifdef DCACHE_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (in_resp) begin
      if (hit_q) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else       perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_main_pipe.sv
// Directed scoreboard bench for dcache_main_pipe.
// Define DCACHE_PERF_CNT_EN to also check the performance counters.
module tb_dcache_main_pipe;
  import dcache_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dcache_main_pipe_if bus();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  dcache_main_pipe dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .perf_hit_cnt  (perf_hit_cnt),
    .perf_miss_cnt (perf_miss_cnt)
`endif
  );

  typedef struct {
    logic [31:0]  data;
    logic         wen;
    logic         dirty;
    logic [127:0] line;
    logic [7:0]   way;
    logic [7:0]   idx;
    logic [19:0]  tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int wen_seen = 0;
  int resp_seen = 0;

  always @(negedge clock) begin
    if (bus.arr_wen)    wen_seen++;
    if (bus.resp_valid) resp_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] merge_model(
    input logic [127:0] ln, input logic [31:0] a,
    input logic [31:0] sd, input logic [3:0] m, input logic st);
    logic [127:0] r;
    int w;
    r = ln;
    w = int'(a[3:2]);
    for (int j = 0; j < 4; j++)
      if (st && m[j]) r[w*32 + j*8 +: 8] = sd[j*8 +: 8];
    return r;
  endfunction

  task automatic issue(
    input logic [31:0] a, input logic h, input logic [7:0] w,
    input logic d, input logic [19:0] dt, input logic [127:0] ln,
    input logic st, input logic [31:0] sd, input logic [3:0] m,
    input logic [127:0] fill);
    exp_t e;
    logic [127:0] mg;
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.in_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_at_issue", bus.in_ready, 1'b1);
    bus.in_addr         = a;
    bus.in_hit          = h;
    bus.in_chosen_way   = w;
    bus.in_is_dirty_way = d;
    bus.in_dirty_tag    = dt;
    bus.in_data         = ln;
    bus.in_is_store     = st;
    bus.in_store_data   = sd;
    bus.in_store_mask   = m;
    bus.in_valid        = 1'b1;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    mg      = merge_model(h ? ln : fill, a, sd, m, st);
    e.data  = st ? 32'h0 : mg[int'(a[3:2])*32 +: 32];
    e.wen   = st | ~h;
    e.dirty = st | (h & d);
    e.line  = mg;
    e.way   = w;
    e.idx   = a[11:4];
    e.tag   = a[31:12];
    sb.push_back(e);
  endtask

  task automatic mem_accept(input string tag, input logic wr,
                            input logic [31:0] a, input logic [127:0] dat,
                            input int stall);
    @(negedge clock);
    for (int i = 0; i <= stall; i++) begin
      chk({tag, "_valid"}, bus.mem_req_valid, 1'b1);
      chk({tag, "_write"}, bus.mem_req_write, wr);
      chk({tag, "_addr"}, bus.mem_req_addr, a);
      if (wr) chk({tag, "_data"}, bus.mem_req_data, dat);
      if (stall > 0) begin
        chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
        chk({tag, "_no_resp"}, bus.resp_valid, 1'b0);
      end
      if (i < stall) @(negedge clock);
    end
    bus.mem_req_ready = 1'b1;
    @(posedge clock);
    #1 bus.mem_req_ready = 1'b0;
  endtask

  task automatic refill(input logic [127:0] dat);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = dat;
    @(posedge clock);
    #1 bus.mem_resp_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.resp_valid && n < 8) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, n, 0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 1'b1);
    chk({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_resp_data"}, bus.resp_data, e.data);
    chk({tag, "_arr_wen"}, bus.arr_wen, e.wen);
    chk({tag, "_arr_dirty"}, bus.arr_dirty, e.dirty);
    if (e.wen) begin
      chk({tag, "_arr_data"}, bus.arr_data, e.line);
      chk({tag, "_arr_way"}, bus.arr_way, e.way);
      chk({tag, "_arr_idx"}, bus.arr_idx, e.idx);
      chk({tag, "_arr_tag"}, bus.arr_tag, e.tag);
    end
  endtask

  localparam logic [127:0] L1 =
    {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] L2 =
    {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
  localparam logic [127:0] F1 =
    {32'h0F0F0F0F, 32'hA5A5A5A5, 32'h12345678, 32'h87654321};
  localparam logic [127:0] F2 =
    {32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
  localparam logic [127:0] L3 =
    {32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666};

  initial begin
    reset              = 1'b1;
    bus.in_valid       = 1'b0;
    bus.in_addr        = '0;
    bus.in_hit         = 1'b0;
    bus.in_chosen_way  = '0;
    bus.in_is_dirty_way = 1'b0;
    bus.in_dirty_tag   = '0;
    bus.in_data        = '0;
    bus.in_is_store    = 1'b0;
    bus.in_store_data  = '0;
    bus.in_store_mask  = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_arr_wen", bus.arr_wen, 1'b0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_arr_data", bus.arr_data, 128'h0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    reset = 1'b0;

    // Miss aborted by reset while waiting for refill data.
    issue(32'h00007020, 1'b0, 8'h04, 1'b0, 20'h0, L1,
          1'b0, 32'h0, 4'h0, F1);
    mem_accept("abort_rd", 1'b0, 32'h00007020, L1, 0);
    @(negedge clock);
    chk("abort_in_wait_ready", bus.in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", bus.in_ready, 1'b1);
    chk("abort_arr_wen", bus.arr_wen, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    sb.delete();
    refill(F1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stray_resp_valid", bus.resp_valid, 1'b0);
      chk("stray_arr_wen", bus.arr_wen, 1'b0);
      chk("stray_in_ready", bus.in_ready, 1'b1);
    end

    // Load hit: response one cycle after acceptance, no memory traffic.
    issue(32'h00001238, 1'b1, 8'h01, 1'b0, 20'h0, L1,
          1'b0, 32'h0, 4'h0, 128'h0);
    check_resp("ld_hit");
    chk("ld_hit_word", bus.resp_data, 32'h33333333);
    chk("ld_hit_no_mem", bus.mem_req_valid, 1'b0);
    chk("ld_hit_busy", bus.in_ready, 1'b0);
    @(negedge clock);
    chk("ld_hit_ready_t2", bus.in_ready, 1'b1);
    chk("ld_hit_resp_gone", bus.resp_valid, 1'b0);

    // Store hit with partial mask.
    issue(32'h00001234, 1'b1, 8'h02, 1'b0, 20'h0, L1,
          1'b1, 32'hAABBCCDD, 4'b0101, 128'h0);
    check_resp("st_hit");
    chk("st_hit_word1", bus.arr_data[63:32], 32'h22BB22DD);
    chk("st_hit_dirty", bus.arr_dirty, 1'b1);

    // Dirty load miss: writeback, refill read, then install clean.
    issue(32'h00005010, 1'b0, 8'h80, 1'b1, 20'h12345, L2,
          1'b0, 32'h0, 4'h0, F1);
    mem_accept("wb", 1'b1, 32'h12345010, L2, 0);
    mem_accept("rd", 1'b0, 32'h00005010, L2, 0);
    refill(F1);
    check_resp("ld_miss");
    chk("ld_miss_word0", bus.resp_data, 32'h87654321);

    // Clean store miss with memory stalled five cycles.
    issue(32'h0000A3FC, 1'b0, 8'h10, 1'b0, 20'h0, L3,
          1'b1, 32'hCAFEF00D, 4'b1111, F2);
    mem_accept("stall_rd", 1'b0, 32'h0000A3F0, L3, 5);
    refill(F2);
    check_resp("st_miss");

    // Load hit on a dirty way keeps dirty but writes nothing.
    issue(32'h00000104, 1'b1, 8'h08, 1'b1, 20'h0, L3,
          1'b0, 32'h0, 4'h0, 128'h0);
    check_resp("ld_hit_dirty");
    chk("ld_hit_dirty_word", bus.resp_data, 32'h77777777);

    @(negedge clock);
    chk("total_arr_writes", wen_seen, 3);
    chk("total_resps", resp_seen, 5);
    chk("sb_drained", sb.size(), 0);
`ifdef DCACHE_PERF_CNT_EN
    chk("perf_hit_cnt", perf_hit_cnt, 32'd3);
    chk("perf_miss_cnt", perf_miss_cnt, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
